// File: rtl/mem_lsu_if.sv
// Data-bus side of the MEM-stage load/store unit: request channel out, read-data channel back.
interface mem_lsu_if;
  // Handshake: bus_req_o stays high with addr/we/be/wdata stable until the cycle bus_gnt_i is seen
  // high; a granted load is then completed by a single-cycle bus_rvalid_i carrying bus_rdata_i.
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid bus access, byte lanes, load extension, registered WB.
// Define MEM_MISALIGN_CHK_EN to reject misaligned half/word accesses and add the misalign_o port.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  mem_lsu_if.master   bus,
  output logic        wb_valid_o,
  output logic        wb_reg_we_o,
  output logic [4:0]  wb_reg_waddr_o,
  output logic [31:0] wb_reg_wdata_o,
  output logic        hold_flag_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic          pass_fire, req_fire, st_done, ld_done, tmo_fire, in_req;

  logic [1:0]    eff_off;
  logic [3:0]    be_in;
  logic [31:0]   wdata_fmt;

  logic          we_q, uns_q, rwe_q;
  logic [1:0]    size_q, off_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [4:0]    rwaddr_q;

  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

`ifdef MEM_MISALIGN_CHK_EN
  logic misaligned, mis_fire;
  assign misaligned = (size_i == 2'b01 && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
`endif

  // Low address bits that do not fit the access size are dropped before lane selection.
  always_comb begin
    eff_off   = addr_i[1:0];
    be_in     = 4'b1111;
    wdata_fmt = wdata_i;
    if (size_i[1]) eff_off = 2'b00;
    else if (size_i[0]) eff_off = {addr_i[1], 1'b0};
    if (mem_we_i) begin
      case (size_i)
        2'b00: begin
          be_in     = 4'b0001 << eff_off;
          wdata_fmt = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be_in     = 4'b0011 << eff_off;
          wdata_fmt = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pass_fire   = 1'b0;
    req_fire    = 1'b0;
    st_done     = 1'b0;
    ld_done     = 1'b0;
    tmo_fire    = 1'b0;
    in_req      = 1'b0;
    hold_flag_o = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
    mis_fire    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (valid_i) begin
          if (!mem_req_i) pass_fire = 1'b1;
`ifdef MEM_MISALIGN_CHK_EN
          else if (misaligned) mis_fire = 1'b1;
`endif
          else begin
            req_fire    = 1'b1;
            hold_flag_o = 1'b1;
            state_nxt   = REQ;
          end
        end
      end
      REQ: begin
        in_req      = 1'b1;
        hold_flag_o = 1'b1;
        if (bus.bus_gnt_i) begin
          if (we_q) begin
            st_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RSP;
          end
        end
      end
      RSP: begin
        hold_flag_o = 1'b1;
        // Data arriving on the last allowed cycle still completes normally.
        if (bus.bus_rvalid_i) begin
          ld_done   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state != RSP)   tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      rwe_q    <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      rwaddr_q <= '0;
    end else if (req_fire) begin
      we_q     <= mem_we_i;
      uns_q    <= unsigned_i;
      rwe_q    <= reg_we_i;
      size_q   <= size_i;
      off_q    <= eff_off;
      addr_q   <= {addr_i[31:2], 2'b00};
      wdata_q  <= wdata_fmt;
      be_q     <= be_in;
      rwaddr_q <= reg_waddr_i;
    end
  end

  assign bus.bus_req_o   = in_req;
  assign bus.bus_we_o    = in_req & we_q;
  assign bus.bus_addr_o  = in_req ? addr_q  : '0;
  assign bus.bus_be_o    = in_req ? be_q    : 4'b0000;
  assign bus.bus_wdata_o = in_req ? wdata_q : '0;

  always_comb begin
    ld_byte = bus.bus_rdata_i[{off_q, 3'b000} +: 8];
    ld_half = bus.bus_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = bus.bus_rdata_i;
    endcase
  end

  // wb_reg_we_o is qualified here so rd is never written outside the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o     <= 1'b0;
      wb_reg_we_o    <= 1'b0;
      wb_reg_waddr_o <= '0;
      wb_reg_wdata_o <= '0;
      bus_err_o      <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_o     <= 1'b0;
`endif
    end else begin
      wb_valid_o  <= 1'b0;
      wb_reg_we_o <= 1'b0;
      bus_err_o   <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      misalign_o  <= 1'b0;
      if (mis_fire) begin
        wb_valid_o <= 1'b1;
        misalign_o <= 1'b1;
      end
`endif
      if (pass_fire) begin
        wb_valid_o     <= 1'b1;
        wb_reg_we_o    <= reg_we_i;
        wb_reg_waddr_o <= reg_waddr_i;
        wb_reg_wdata_o <= reg_wdata_i;
      end
      if (st_done || tmo_fire) begin
        wb_valid_o <= 1'b1;
        bus_err_o  <= tmo_fire;
      end
      if (ld_done) begin
        wb_valid_o     <= 1'b1;
        wb_reg_we_o    <= rwe_q;
        wb_reg_waddr_o <= rwaddr_q;
        wb_reg_wdata_o <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: transaction-level model predicting every cycle, random and directed accesses.
module tb_mem_lsu;
  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        valid_i, mem_req_i, mem_we_i, unsigned_i, reg_we_i;
  logic [31:0] addr_i, wdata_i, reg_wdata_i;
  logic [1:0]  size_i;
  logic [4:0]  reg_waddr_i;
  logic        wb_valid_o, wb_reg_we_o, hold_flag_o, bus_err_o;
  logic [4:0]  wb_reg_waddr_o;
  logic [31:0] wb_reg_wdata_o;
  logic [1:0]  dbg_state;
  logic        mis_out;

  mem_lsu_if bus_if ();

  mem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .bus(bus_if),
    .wb_valid_o(wb_valid_o), .wb_reg_we_o(wb_reg_we_o), .wb_reg_waddr_o(wb_reg_waddr_o),
    .wb_reg_wdata_o(wb_reg_wdata_o), .hold_flag_o(hold_flag_o), .bus_err_o(bus_err_o),
    .dbg_state(dbg_state)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign_o(mis_out)
`endif
  );

`ifndef MEM_MISALIGN_CHK_EN
  assign mis_out = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic        all_chk;
    logic        hold;
    logic        breq;
    logic        bwe;
    logic [31:0] baddr;
    logic [3:0]  bbe;
    logic [31:0] bwdata;
    logic        wbv;
    logic        wbwe;
    logic        wbfull;
    logic [4:0]  wbaddr;
    logic [31:0] wbdata;
    logic        err;
    logic        mis;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];
  exp_t pend;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // driver tasks
  task automatic step_begin();
    @(posedge clk);
    #1;
  endtask

  // Merge a write-back completed on the previous cycle into this cycle's expectation.
  task automatic push(input exp_t e);
    if (pend.wbv) begin
      e.wbv    = 1'b1;
      e.wbwe   = pend.wbwe;
      e.wbfull = pend.wbfull;
      e.wbaddr = pend.wbaddr;
      e.wbdata = pend.wbdata;
      e.err    = pend.err;
      e.mis    = pend.mis;
    end
    pend = '0;
    exp_q.push_back(e);
  endtask

  task automatic scramble();
    valid_i     = 1'($urandom_range(0, 1));
    mem_req_i   = 1'($urandom_range(0, 1));
    mem_we_i    = 1'($urandom_range(0, 1));
    addr_i      = $urandom;
    wdata_i     = $urandom;
    size_i      = 2'($urandom_range(0, 3));
    unsigned_i  = 1'($urandom_range(0, 1));
    reg_we_i    = 1'($urandom_range(0, 1));
    reg_waddr_i = 5'($urandom_range(0, 31));
    reg_wdata_i = $urandom;
    bus_if.bus_rdata_i = $urandom;
  endtask

  task automatic idle();
    exp_t e;
    step_begin();
    scramble();
    valid_i = 1'b0;
    bus_if.bus_gnt_i = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    e = '0;
    push(e);
  endtask

  // kind: 0 pass-through, 1 load, 2 store. gd = cycles before grant, rd = RSP cycles before rvalid.
  task automatic do_instr(input int kind, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd, input logic rwe,
                          input logic [4:0] rwa, input logic [31:0] rwd, input int gd,
                          input int rd, input logic [31:0] rdata);
    exp_t e;
    int n, off, eo;
    logic mis;
    logic [3:0] be;
    logic [31:0] bwd, ld;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
    mis = (kind != 0) && (off % n != 0);
`endif
    eo = off - (off % n);
    be = 4'b0000;
    bwd = '0;
    for (int i = 0; i < 4; i++) begin
      be[i] = (i >= eo) && (i < eo + n);
      bwd[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    ld = '0;
    for (int j = 0; j < n; j++) ld[8*j +: 8] = rdata[8*(eo + j) +: 8];
    if (!uns && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8*n));

    step_begin();
    valid_i = 1'b1; mem_req_i = (kind != 0); mem_we_i = (kind == 2);
    addr_i = addr; wdata_i = wd; size_i = size; unsigned_i = uns;
    reg_we_i = rwe; reg_waddr_i = rwa; reg_wdata_i = rwd;
    bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0; bus_if.bus_rdata_i = $urandom;
    e = '0;
    e.hold = (kind != 0) && !mis;
    push(e);
    if (kind == 0 || mis) begin
      pend.wbv = 1'b1; pend.wbwe = (kind == 0) ? rwe : 1'b0; pend.wbfull = (kind == 0);
      pend.wbaddr = rwa; pend.wbdata = rwd; pend.mis = mis;
      return;
    end
    for (int g = 0; g <= gd; g++) begin
      step_begin();
      scramble();
      bus_if.bus_gnt_i = (g == gd); bus_if.bus_rvalid_i = 1'b0;
      e = '0;
      e.hold = 1'b1; e.breq = 1'b1; e.bwe = (kind == 2);
      e.baddr = {addr[31:2], 2'b00}; e.bbe = (kind == 2) ? be : 4'b1111; e.bwdata = bwd;
      push(e);
    end
    if (kind == 2) begin
      pend.wbv = 1'b1;
      return;
    end
    for (int r = 0; r < TMO; r++) begin
      step_begin();
      scramble();
      bus_if.bus_gnt_i = 1'b0;
      bus_if.bus_rvalid_i = (r == rd);
      if (r == rd) bus_if.bus_rdata_i = rdata;
      e = '0;
      e.hold = 1'b1;
      push(e);
      if (r == rd) begin
        pend.wbv = 1'b1; pend.wbwe = rwe; pend.wbfull = 1'b1; pend.wbaddr = rwa; pend.wbdata = ld;
        return;
      end
      if (r == TMO - 1) begin
        pend.wbv = 1'b1; pend.err = 1'b1;
        return;
      end
    end
  endtask

  task automatic zero_cycle(input logic rst_val);
    exp_t e;
    step_begin();
    rst_n = rst_val;
    scramble();
    valid_i = 1'b0;
    bus_if.bus_gnt_i = 1'b0;
    bus_if.bus_rvalid_i = 1'($urandom_range(0, 1));
    pend = '0;
    e = '0;
    e.all_chk = 1'b1;
    push(e);
  endtask

  // scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hold_flag", 32'(hold_flag_o), 32'(e.hold));
        chk("bus_req", 32'(bus_if.bus_req_o), 32'(e.breq));
        chk("wb_valid", 32'(wb_valid_o), 32'(e.wbv));
        chk("bus_err", 32'(bus_err_o), 32'(e.err));
`ifdef MEM_MISALIGN_CHK_EN
        chk("misalign", 32'(mis_out), 32'(e.mis));
`endif
        if (e.all_chk || e.breq) begin
          chk("bus_we", 32'(bus_if.bus_we_o), 32'(e.bwe));
          chk("bus_addr", bus_if.bus_addr_o, e.baddr);
          chk("bus_be", 32'(bus_if.bus_be_o), 32'(e.bbe));
        end
        if (e.all_chk || e.bwe) chk("bus_wdata", bus_if.bus_wdata_o, e.bwdata);
        if (e.all_chk || e.wbv) chk("wb_reg_we", 32'(wb_reg_we_o), 32'(e.wbwe));
        if (e.all_chk || e.wbfull) begin
          chk("wb_reg_waddr", 32'(wb_reg_waddr_o), 32'(e.wbaddr));
          chk("wb_reg_wdata", wb_reg_wdata_o, e.wbdata);
        end
      end
    end
  end

  initial begin
    int kind;
    pend = '0;
    rst_n = 1'b0;
    valid_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; addr_i = '0; wdata_i = '0;
    size_i = 2'b00; unsigned_i = 1'b0; reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
    bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0; bus_if.bus_rdata_i = '0;

    for (int i = 0; i < 3; i++) zero_cycle(1'b0);
    zero_cycle(1'b1);

    // LB 0x1003 -> sign-extended top byte
    do_instr(1, 32'h1003, 2'b00, 1'b0, 32'h0, 1'b1, 5'd7, 32'h0, 0, 0, 32'h80FF_FFFF);
    idle();
    @(negedge clk);
    chk("lit_lb_data", wb_reg_wdata_o, 32'hFFFF_FF80);
    chk("lit_lb_we", 32'(wb_reg_we_o), 32'd1);

    do_instr(1, 32'h2002, 2'b01, 1'b1, 32'h0, 1'b1, 5'd8, 32'h0, 0, 0, 32'hBEEF_1234);
    idle();
    @(negedge clk);
    chk("lit_lhu_data", wb_reg_wdata_o, 32'h0000_BEEF);

    do_instr(1, 32'h2002, 2'b01, 1'b0, 32'h0, 1'b1, 5'd9, 32'h0, 1, 2, 32'hBEEF_1234);
    idle();
    @(negedge clk);
    chk("lit_lh_data", wb_reg_wdata_o, 32'hFFFF_BEEF);

    // SB with grant three cycles late
    do_instr(2, 32'h3001, 2'b00, 1'b0, 32'h0000_00A5, 1'b0, 5'd0, 32'h0, 3, 0, 32'h0);
    @(negedge clk);
    chk("lit_sb_be", 32'(bus_if.bus_be_o), 32'h2);
    chk("lit_sb_wdata", bus_if.bus_wdata_o, 32'hA5A5_A5A5);
    idle();
    @(negedge clk);
    chk("lit_sb_wb", 32'(wb_valid_o), 32'd1);
    chk("lit_sb_hold", 32'(hold_flag_o), 32'd0);

    // load timeout
    do_instr(1, 32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 5'd4, 32'h0, 0, 99, 32'h0);
    idle();
    @(negedge clk);
    chk("lit_tmo_err", 32'(bus_err_o), 32'd1);
    chk("lit_tmo_we", 32'(wb_reg_we_o), 32'd0);

    // ADD then LW back to back
    do_instr(0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 5'd3, 32'h1234, 0, 0, 32'h0);
    fork
      begin
        @(posedge clk);
        @(negedge clk);
        chk("lit_add_wb", wb_reg_wdata_o, 32'h1234);
        chk("lit_lw_hold", 32'(hold_flag_o), 32'd1);
      end
    join_none
    do_instr(1, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 5'd10, 32'h0, 1, 1, 32'hCAFE_F00D);
    idle();
    @(negedge clk);
    chk("lit_lw_data", wb_reg_wdata_o, 32'hCAFE_F00D);

`ifdef MEM_MISALIGN_CHK_EN
    do_instr(1, 32'h2, 2'b10, 1'b0, 32'h0, 1'b1, 5'd11, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk("lit_mis_req", 32'(bus_if.bus_req_o), 32'd0);
    idle();
    @(negedge clk);
    chk("lit_mis_flag", 32'(mis_out), 32'd1);
`endif

    // reset while waiting for read data
    do_instr(1, 32'h50, 2'b10, 1'b0, 32'h0, 1'b1, 5'd12, 32'h0, 0, 99, 32'h0);
    exp_q.delete();
    pend = '0;
    zero_cycle(1'b0);
    for (int i = 0; i < 3; i++) zero_cycle(1'b1);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) idle();
      do_instr(kind, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 5), $urandom);
    end
    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
